// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for keypad operand entry.
// State encodings, special key codes and the digit-count limit.
package keypad_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    PRESENT = 2'd2
  } entry_state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd14;

  localparam logic [2:0] DIGIT_MAX = 3'd4;

endpackage

// File: rtl/keypad_key_decode.sv
// keypad_key_decode: combinational keypad scan-index decoder.
// In: key_code[3:0]. Out: is_digit, is_clear, is_enter, nibble[3:0].
module keypad_key_decode
  import keypad_pkg::*;
(
  input  logic [3:0] key_code,
  output logic       is_digit,
  output logic       is_clear,
  output logic       is_enter,
  output logic [3:0] nibble
);

  always_comb begin
    is_digit = 1'b1;
    is_clear = 1'b0;
    is_enter = 1'b0;
    nibble   = 4'h0;
    unique case (key_code)
      4'd0:  nibble = 4'h1;
      4'd1:  nibble = 4'h2;
      4'd2:  nibble = 4'h3;
      4'd3:  nibble = 4'hA;
      4'd4:  nibble = 4'h4;
      4'd5:  nibble = 4'h5;
      4'd6:  nibble = 4'h6;
      4'd7:  nibble = 4'hB;
      4'd8:  nibble = 4'h7;
      4'd9:  nibble = 4'h8;
      4'd10: nibble = 4'h9;
      4'd11: nibble = 4'hC;
      4'd13: nibble = 4'h0;
      4'd15: nibble = 4'hD;
      KEY_CLEAR: begin
        is_digit = 1'b0;
        is_clear = 1'b1;
      end
      KEY_ENTER: begin
        is_digit = 1'b0;
        is_enter = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry: builds two FP16 operands from keypad digits.
// In: clk, reset, key_valid, key_code[3:0], op_ready.
// Out: op_a, op_b, op_valid, entry_value, digit_count, entry_state, err.
module keypad_operand_entry
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] entry_value,
  output logic [2:0]  digit_count,
  output logic [1:0]  entry_state,
  output logic        err
);

  entry_state_t state, state_n;
  logic [15:0]  entry_n, op_a_n, op_b_n;
  logic [2:0]   count_n;
  logic         err_n;

  logic         is_digit, is_clear, is_enter;
  logic [3:0]   nibble;

  keypad_key_decode u_dec (
    .key_code (key_code),
    .is_digit (is_digit),
    .is_clear (is_clear),
    .is_enter (is_enter),
    .nibble   (nibble)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ENTER_A;
      entry_value <= 16'h0;
      digit_count <= 3'd0;
      op_a        <= 16'h0;
      op_b        <= 16'h0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      entry_value <= entry_n;
      digit_count <= count_n;
      op_a        <= op_a_n;
      op_b        <= op_b_n;
      err         <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    entry_n = entry_value;
    count_n = digit_count;
    op_a_n  = op_a;
    op_b_n  = op_b;
    err_n   = 1'b0;
    if (state == PRESENT) begin
      // keys are dropped here, even on the handshake cycle
      if (op_ready) state_n = ENTER_A;
    end else if (key_valid) begin
      unique case (1'b1)
        is_digit: begin
          if (digit_count < DIGIT_MAX) begin
            entry_n = {entry_value[11:0], nibble};
            count_n = digit_count + 3'd1;
          end else begin
            err_n = 1'b1;
          end
        end
        is_clear: begin
          entry_n = 16'h0;
          count_n = 3'd0;
        end
        is_enter: begin
          if (digit_count == DIGIT_MAX) begin
            if (state == ENTER_A) begin
              op_a_n  = entry_value;
              state_n = ENTER_B;
            end else begin
              op_b_n  = entry_value;
              state_n = PRESENT;
            end
            entry_n = 16'h0;
            count_n = 3'd0;
          end else begin
            err_n = 1'b1;
          end
        end
      endcase
    end
  end

  // state is a register, so op_valid never sees op_ready combinationally
  assign op_valid    = (state == PRESENT);
  assign entry_state = state;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// tb_keypad_operand_entry: directed self-checking bench.
// Drives key presses on negedge, checks outputs on the following negedge.
module tb_keypad_operand_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        op_ready;
  logic [15:0] op_a, op_b, entry_value;
  logic        op_valid, err;
  logic [2:0]  digit_count;
  logic [1:0]  entry_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  keypad_operand_entry dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .entry_value (entry_value),
    .digit_count (digit_count),
    .entry_state (entry_state),
    .err         (err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic entry(input string tag,
                       input logic [15:0] v,
                       input logic [2:0] n,
                       input logic [1:0] s);
    check({tag, " entry"}, 32'(entry_value), 32'(v));
    check({tag, " count"}, 32'(digit_count), 32'(n));
    check({tag, " state"}, 32'(entry_state), 32'(s));
  endtask

  task automatic all_zero(input string tag);
    check({tag, " op_a"}, 32'(op_a), 32'h0);
    check({tag, " op_b"}, 32'(op_b), 32'h0);
    check({tag, " op_valid"}, 32'(op_valid), 32'h0);
    check({tag, " err"}, 32'(err), 32'h0);
    entry(tag, 16'h0, 3'd0, 2'd0);
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    op_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    all_zero("reset");
    reset = 1'b0;

    // op_a = 0x3C00 (keys 2,11,13,13); op_ready ignored here
    op_ready = 1'b1;
    press(4'd2); press(4'd11);
    op_ready = 1'b0;
    press(4'd13); press(4'd13);
    entry("a_digits", 16'h3C00, 3'd4, 2'd0);
    press(4'd14);
    check("a_op_a", 32'(op_a), 32'h3C00);
    check("a_err", 32'(err), 32'h0);
    entry("a_enter", 16'h0, 3'd0, 2'd1);

    // op_b = 0x0400 (keys 13,4,13,13)
    press(4'd13); press(4'd4);
    press(4'd13); press(4'd13);
    press(4'd14);
    check("b_op_b", 32'(op_b), 32'h0400);
    check("b_op_a", 32'(op_a), 32'h3C00);
    check("b_valid", 32'(op_valid), 32'h1);
    check("b_state", 32'(entry_state), 32'h2);

    // keys ignored in PRESENT
    press(4'd0);
    check("p_err0", 32'(err), 32'h0);
    press(4'd12);
    check("p_err1", 32'(err), 32'h0);
    check("p_op_a", 32'(op_a), 32'h3C00);
    check("p_op_b", 32'(op_b), 32'h0400);
    check("p_valid", 32'(op_valid), 32'h1);
    check("p_entry", 32'(entry_value), 32'h0);

    // handshake, with a coinciding key that must be dropped
    op_ready = 1'b1;
    press(4'd5);
    op_ready = 1'b0;
    check("hs_valid", 32'(op_valid), 32'h0);
    check("hs_err", 32'(err), 32'h0);
    entry("hs", 16'h0, 3'd0, 2'd0);
    check("hs_op_a", 32'(op_a), 32'h3C00);
    check("hs_op_b", 32'(op_b), 32'h0400);

    // overflow: 0,1,2,3 -> 0x123A, 5th digit rejected
    press(4'd0); press(4'd1);
    press(4'd2); press(4'd3);
    press(4'd5);
    check("ovf_err", 32'(err), 32'h1);
    entry("ovf", 16'h123A, 3'd4, 2'd0);
    @(negedge clk);
    check("ovf_err_drop", 32'(err), 32'h0);
    press(4'd12);
    check("clr_err", 32'(err), 32'h0);
    entry("clr", 16'h0, 3'd0, 2'd0);

    // short ENTER rejected, then CLEAR
    press(4'd0); press(4'd1);
    press(4'd14);
    check("short_err", 32'(err), 32'h1);
    entry("short", 16'h0012, 3'd2, 2'd0);
    check("short_op_a", 32'(op_a), 32'h3C00);
    press(4'd12);
    check("short_clr_err", 32'(err), 32'h0);
    entry("short_clr", 16'h0, 3'd0, 2'd0);

    // remaining map entries: 10,15,7,8 -> 0x9DB7
    press(4'd10); press(4'd15);
    press(4'd7); press(4'd8);
    entry("map", 16'h9DB7, 3'd4, 2'd0);
    press(4'd14);
    check("map_op_a", 32'(op_a), 32'h9DB7);

    // mid-entry reset in ENTER_B with three digits
    press(4'd6); press(4'd9); press(4'd3);
    entry("pre_rst", 16'h68A, 3'd3, 2'd1);
    reset = 1'b1;
    press(4'd4);
    all_zero("mid_rst");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
